// File: rtl/fp_divsqrt_if.sv
// Request/response bundle for the sequential FP divide/square-root unit.
// The master drives requests and accepts results. The slave is the unit itself.
interface fp_divsqrt_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         kill;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         div_zero;
  logic         invalid;
  logic         busy;

  modport master (
    output in_valid, op, x, y, kill, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, div_zero, invalid, busy
  );

  modport slave (
    input  in_valid, op, x, y, kill, out_ready,
    output in_ready, out_valid, result, overflow, underflow, div_zero, invalid, busy
  );
endinterface

// File: rtl/fp_divsqrt_seq.sv
// Sequential FP divide / square root: one quotient or root bit per cycle,
// RNE rounding, with special operands resolved at accept time.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// SPECIAL | special-case result already latched, one cycle to DONE
// CALC    | restoring div/sqrt recurrence, counted down from ITER
// NORM    | normalise, round, range check, latch result
// DONE    | out_valid high until out_ready
module fp_divsqrt_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_divsqrt_if.slave  bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int ITER = MAN_W + 3;
  localparam int QW   = MAN_W + 3;
  localparam int RW   = MAN_W + 7;
  localparam int RADW = 2 * QW;
  localparam int EW   = EXP_W + 3;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SPECIAL = 3'd1;
  localparam logic [2:0] ST_CALC    = 3'd2;
  localparam logic [2:0] ST_NORM    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_SQRT = 5'b00101;

  localparam logic signed [EW-1:0] BIAS    = EW'(2**(EXP_W-1) - 1);
  localparam logic [EW-1:0]        EXP_MAX = EW'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0]     E_ONES  = '1;
  localparam logic [W-1:0] QNAN = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic                   is_sqrt;
  logic                   sign_r;
  logic signed [EW-1:0]   exp_r;
  logic [QW-1:0]          q;
  logic [RW-1:0]          rem;
  logic [RADW-1:0]        rad;
  logic [MAN_W:0]         dvsr;
  logic [W-1:0]           result_r;
  logic                   ovf_r, unf_r, dz_r, inv_r;

  logic                   sx, sy;
  logic [EXP_W-1:0]       ex, ey;
  logic [MAN_W-1:0]       fx, fy;
  logic                   x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic                   accept;

  assign sx = bus.x[W-1];
  assign sy = bus.y[W-1];
  assign ex = bus.x[W-2:MAN_W];
  assign ey = bus.y[W-2:MAN_W];
  assign fx = bus.x[MAN_W-1:0];
  assign fy = bus.y[MAN_W-1:0];

  // Denormals have a zero exponent and are folded into zero here.
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_inf  = (ex == E_ONES) && (fx == '0);
  assign y_inf  = (ey == E_ONES) && (fy == '0);
  assign x_nan  = (ex == E_ONES) && (fx != '0);
  assign y_nan  = (ey == E_ONES) && (fy != '0);

  assign accept = bus.in_valid && (state == ST_IDLE) && !bus.kill;

  logic           sp_hit, sp_inv, sp_dz;
  logic [W-1:0]   sp_res;

  always_comb begin
    sp_hit = 1'b1;
    sp_res = QNAN;
    sp_inv = 1'b0;
    sp_dz  = 1'b0;
    if (bus.op == OP_DIV) begin
      if (x_nan || y_nan)                          sp_res = QNAN;
      else if ((x_zero && y_zero) || (x_inf && y_inf)) sp_inv = 1'b1;
      else if (y_zero) begin
        sp_res = {sx ^ sy, E_ONES, {MAN_W{1'b0}}};
        sp_dz  = 1'b1;
      end
      else if (x_inf)                              sp_res = {sx ^ sy, E_ONES, {MAN_W{1'b0}}};
      else if (x_zero || y_inf)                    sp_res = {sx ^ sy, {(W-1){1'b0}}};
      else                                         sp_hit = 1'b0;
    end else if (bus.op == OP_SQRT) begin
      if (x_nan)       sp_res = QNAN;
      else if (x_zero) sp_res = {sx, {(W-1){1'b0}}};
      else if (sx)     sp_inv = 1'b1;
      else if (x_inf)  sp_res = {1'b0, E_ONES, {MAN_W{1'b0}}};
      else             sp_hit = 1'b0;
    end else begin
      sp_res = bus.x;
    end
  end

  logic signed [EW-1:0] ex_s, ey_s, div_exp, sqrt_unb, sqrt_exp;

  assign ex_s     = $signed({{(EW-EXP_W){1'b0}}, ex});
  assign ey_s     = $signed({{(EW-EXP_W){1'b0}}, ey});
  assign div_exp  = ex_s - ey_s + BIAS;
  assign sqrt_unb = ex_s - BIAS;
  assign sqrt_exp = (sqrt_unb >>> 1) + BIAS;

  // Recurrence step for both operations; the radicand is fed two bits per step.
  logic [RW-1:0] dvsr_ext, s_cat, s_sub;
  logic          d_ge, s_ge;

  assign dvsr_ext = RW'(dvsr);
  assign d_ge     = (rem >= dvsr_ext);
  assign s_cat    = (rem << 2) | RW'(rad[RADW-1 -: 2]);
  assign s_sub    = RW'({q, 2'b01});
  assign s_ge     = (s_cat >= s_sub);

  logic                 msb, g_bit, st_bit, rnd, carry;
  logic [MAN_W:0]       man;
  logic [MAN_W+1:0]     sum;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] exp_n, exp_f;
  logic                 nr_ovf, nr_unf;
  logic [W-1:0]         nr_res;

  always_comb begin
    msb    = q[QW-1];
    man    = msb ? q[QW-1:2] : q[QW-2:1];
    g_bit  = msb ? q[1] : q[0];
    st_bit = (msb && q[0]) || (rem != '0);
    exp_n  = msb ? exp_r : exp_r - EW'(1);
    rnd    = g_bit && (st_bit || man[0]);
    sum    = {1'b0, man} + (MAN_W+2)'(rnd);
    carry  = sum[MAN_W+1];
    frac   = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_f  = carry ? exp_n + EW'(1) : exp_n;
    nr_unf = exp_f[EW-1] || (exp_f == '0);
    nr_ovf = !exp_f[EW-1] && (exp_f >= EXP_MAX);
    if (nr_ovf)      nr_res = {sign_r, E_ONES, {MAN_W{1'b0}}};
    else if (nr_unf) nr_res = {sign_r, {(W-1){1'b0}}};
    else             nr_res = {sign_r, exp_f[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_sqrt  <= 1'b0;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      q        <= '0;
      rem      <= '0;
      rad      <= '0;
      dvsr     <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dz_r     <= 1'b0;
      inv_r    <= 1'b0;
    end else if (state != ST_IDLE && bus.kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (sp_hit) begin
              result_r <= sp_res;
              ovf_r    <= 1'b0;
              unf_r    <= 1'b0;
              dz_r     <= sp_dz;
              inv_r    <= sp_inv;
              state    <= ST_SPECIAL;
            end else begin
              is_sqrt <= (bus.op == OP_SQRT);
              cnt     <= CW'(ITER);
              q       <= '0;
              dvsr    <= {1'b1, fy};
              if (bus.op == OP_SQRT) begin
                sign_r <= 1'b0;
                exp_r  <= sqrt_exp;
                rem    <= '0;
                // Odd unbiased exponent: radicand becomes 2*m so the exponent halves evenly.
                rad    <= sqrt_unb[0] ? {1'b1, fx, {(RADW-MAN_W-1){1'b0}}}
                                      : {2'b01, fx, {(RADW-MAN_W-2){1'b0}}};
              end else begin
                sign_r <= sx ^ sy;
                exp_r  <= div_exp;
                rem    <= RW'({1'b1, fx});
                rad    <= '0;
              end
              state <= ST_CALC;
            end
          end
        end
        ST_SPECIAL: state <= ST_DONE;
        ST_CALC: begin
          if (cnt == '0) begin
            state <= ST_NORM;
          end else begin
            cnt <= cnt - CW'(1);
            if (is_sqrt) begin
              q   <= {q[QW-2:0], s_ge};
              rem <= s_ge ? s_cat - s_sub : s_cat;
              rad <= rad << 2;
            end else begin
              q   <= {q[QW-2:0], d_ge};
              rem <= (rem - (d_ge ? dvsr_ext : '0)) << 1;
            end
          end
        end
        ST_NORM: begin
          result_r <= nr_res;
          ovf_r    <= nr_ovf;
          unf_r    <= nr_unf && !nr_ovf;
          dz_r     <= 1'b0;
          inv_r    <= 1'b0;
          state    <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
  assign bus.div_zero  = dz_r;
  assign bus.invalid   = inv_r;
endmodule
